dscope_capture_array: RTL and testbench
=======================================

DSCOPE_CAPTURE_ARRAY -- requirements
Module: dscope_capture_array

Interface
REQ-001 Parameter NCH, default 4: number of ADC channels.
REQ-002 Parameter ADC_W, default 12: ADC sample width per channel.
REQ-003 Parameter DEPTH, default 256: maximum stored samples per channel; power of two, at least 4.
REQ-004 Parameter LEN_W, default $clog2(DEPTH)+1: width of the per-channel length field.
REQ-005 Reset rst_n, asynchronous, active-low; clock adc_clk.
REQ-006 Signal list, one per line (name, direction, width, meaning):
- rst_n, in, 1: asynchronous active-low reset.
- adc_clk, in, 1: sample clock; all logic runs on it.
- i_sync, in, 1: single-cycle frame start.
- i_adc_data, in, NCH*ADC_W: channel c occupies bits [c*ADC_W +: ADC_W].
- i_ratio, in, NCH*8: decimation ratio per channel.
- i_len, in, NCH*LEN_W: stored samples per channel.
- i_mode, in, NCH*2: decimation mode per channel.
- o_out_data, out, 32: packed readout word.
- o_out_vld, out, 1: readout word valid.
- i_out_rdy, in, 1: sink ready.
- o_frame_ready, out, 1: captured frame available for readout.
- o_frame_size, out, 16: frame length in 32-bit words.
- o_busy, out, 1: acquisition or readout in progress.
- o_overrun, out, 1: 1-cycle pulse when i_sync is dropped.

Function
REQ-007 The block SHALL use states IDLE, ACQ and OUT; o_busy SHALL be 1 in ACQ and in OUT.
REQ-008 In IDLE, i_sync=1 SHALL latch i_ratio, i_len and i_mode for all channels and enter ACQ on the next cycle.
- Input changes after the latch SHALL have no effect until the next frame.
REQ-009 The first captured ADC sample SHALL be the one present on the cycle after i_sync.
REQ-010 Ratio handling:
- Ratio 0 SHALL be treated as 1.
- Each group of ratio consecutive samples SHALL produce one stored sample.
REQ-011 Decimation modes:
- Mode 0: the first sample of the group.
- Mode 1: the maximum of the group, unsigned.
- Mode 2: the minimum of the group, unsigned.
- Mode 3: identical to mode 0.
REQ-012 The stored sample SHALL be bits [ADC_W-1 : ADC_W-8] of the group result.
REQ-013 Length handling:
- A length greater than DEPTH SHALL be clamped to DEPTH.
- A channel with length 0 SHALL be complete immediately.
REQ-014 Sample packing: stored sample k of channel c SHALL go to word k/4 of that channel, byte lane k%4; byte 0 is bits [7:0].
REQ-015 A channel SHALL stop storing after its length is reached; channels complete independently of one another.
REQ-016 When all channels are complete, the block SHALL compute o_frame_size = sum over c of ceil(len_c/4) and enter OUT.
- It SHALL assert o_frame_ready in the same cycle as o_frame_size becomes valid.
- If o_frame_size is 0, it SHALL return to IDLE with no o_frame_ready and no words.
REQ-017 In OUT, words SHALL stream in order: channel 0 word 0 upward, then channel 1, and so on.
- Channels with length 0 SHALL contribute no words.
- Unused byte lanes of a channel's last word SHALL be 0x00.
REQ-018 The first o_out_vld SHALL assert no more than 3 cycles after o_frame_ready rises.
REQ-019 Handshake: a word transfers when o_out_vld and i_out_rdy are both 1.
- While o_out_vld=1 and i_out_rdy=0, o_out_data SHALL hold stable.
- The block SHALL never deassert vld without a transfer.
REQ-020 Back-to-back transfers at 1 word per cycle SHALL be supported whenever i_out_rdy stays 1.
REQ-021 After the last word transfers, on the next cycle: o_out_vld=0, o_frame_ready=0 and the state is IDLE.
REQ-022 o_frame_size SHALL hold its value until the next frame completes.
REQ-023 i_sync in ACQ or OUT SHALL be ignored and SHALL pulse o_overrun for 1 cycle; the current frame continues unaffected.
REQ-024 i_sync on the same cycle the last word transfers SHALL be treated as overrun and SHALL NOT start a frame.

Reset
REQ-025 Reset SHALL set the state to IDLE, all counters to 0 and all outputs to 0: o_out_data=0, o_out_vld=0, o_frame_ready=0, o_frame_size=0, o_busy=0, o_overrun=0.
REQ-026 Reset asserted mid-ACQ or mid-OUT SHALL abandon the frame.
- After release, nothing SHALL be output until a new i_sync.
REQ-027 Buffer RAM contents need no reset.
- Unwritten byte lanes SHALL still read 0x00 per REQ-017.

Verification
REQ-028 Scenario: NCH=4; channel 0 ramp 0x000,0x010,0x020...; ratio=1, mode=0, len=8; other channels len=0.
- Required response: o_frame_size=2; words 0x03020100 then 0x07060504.
REQ-029 Scenario: channel 0 ratio=4, mode=1, len=2; samples 0x100,0xFF0,0x200,0x300, 0x050,0x060,0x070,0x010.
- Required response: 1 word 0x000007FF.
- Mode=2 with the same samples: 1 word 0x00000110.
REQ-030 Scenario: all channels len=300 with DEPTH=256.
- Required response: each channel clamped to 256; o_frame_size=256; 256 words streamed in channel order.
REQ-031 Scenario: len=5 per channel; i_out_rdy toggles randomly.
- Required response: o_frame_size=8; no word lost or duplicated; data stable while stalled.
- The last word of each channel has bytes 1-3 equal to 0x00.
REQ-032 Scenario: i_sync during ACQ and again during OUT.
- Required response: two o_overrun pulses; frame content unchanged.
- After the last transfer, the next i_sync in IDLE starts a frame normally.
REQ-033 Scenario: rst_n asserted mid-OUT after 3 of 8 words.
- Required response: all outputs 0 immediately; no words after release until a new i_sync.

Source files
------------

// File: rtl/dscope_capture_array.sv
// Multi-channel oscilloscope capture: per-channel decimation into byte-packed buffers,
// then a streamed 32-bit readout of the captured frame over a valid/ready port.
module dscope_capture_array #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned ADC_W = 12,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned LEN_W = $clog2(DEPTH) + 1
) (
    input  logic                 adc_clk,
    input  logic                 rst_n,
    input  logic                 i_sync,
    input  logic [NCH*ADC_W-1:0] i_adc_data,
    input  logic [NCH*8-1:0]     i_ratio,
    input  logic [NCH*LEN_W-1:0] i_len,
    input  logic [NCH*2-1:0]     i_mode,
    output logic [31:0]          o_out_data,
    output logic                 o_out_vld,
    input  logic                 i_out_rdy,
    output logic                 o_frame_ready,
    output logic [15:0]          o_frame_size,
    output logic                 o_busy,
    output logic                 o_overrun
);

    localparam int unsigned NW = DEPTH / 4;
    localparam int unsigned WA = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {StIdle, StAcq, StOut} state_t;

    state_t             state_q;
    logic [7:0]         ratio_q [NCH];
    logic [LEN_W-1:0]   len_q   [NCH];
    logic [1:0]         mode_q  [NCH];
    logic [7:0]         grp_q   [NCH];
    logic [ADC_W-1:0]   acc_q   [NCH];
    logic [LEN_W-1:0]   cnt_q   [NCH];
    logic [NCH-1:0]     done_q;
    logic [LEN_W-1:0]   rd_w_q;
    logic [CW-1:0]      rd_ch_q;
    logic [15:0]        left_q;
    logic [31:0]        mem [NCH][NW];

    logic [ADC_W-1:0]   smp       [NCH];
    logic [ADC_W-1:0]   grp_res   [NCH];
    logic [LEN_W-1:0]   len_clamp [NCH];
    logic [LEN_W-1:0]   nwords    [NCH];
    logic [NCH-1:0]     grp_last;
    logic [NCH-1:0]     wr_en;
    logic [15:0]        size_calc;
    logic [CW-1:0]      first_ch;
    logic [CW-1:0]      next_ch;
    logic [31:0]        rd_word;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            smp[c] = i_adc_data[c*ADC_W +: ADC_W];
            grp_res[c] = acc_q[c];
            if (grp_q[c] == 8'd0) begin
                grp_res[c] = smp[c];
            end else if (mode_q[c] == 2'd1 && smp[c] > acc_q[c]) begin
                grp_res[c] = smp[c];
            end else if (mode_q[c] == 2'd2 && smp[c] < acc_q[c]) begin
                grp_res[c] = smp[c];
            end
            grp_last[c]  = (grp_q[c] == ratio_q[c] - 8'd1);
            wr_en[c]     = (state_q == StAcq) && !done_q[c] && grp_last[c];
            nwords[c]    = LEN_W'(({1'b0, len_q[c]} + (LEN_W+1)'(3)) >> 2);
            len_clamp[c] = (i_len[c*LEN_W +: LEN_W] > LEN_W'(DEPTH)) ? LEN_W'(DEPTH)
                                                                     : i_len[c*LEN_W +: LEN_W];
        end
    end

    // Scan downward so the last hit is the lowest qualifying channel.
    always_comb begin
        size_calc = '0;
        first_ch  = '0;
        next_ch   = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            size_calc = size_calc + 16'(nwords[c]);
            if (nwords[c] != '0) begin
                first_ch = CW'(c);
                if (c > int'(rd_ch_q)) next_ch = CW'(c);
            end
        end
    end

    // Lanes past the channel length read as zero, so stale RAM never leaks out.
    always_comb begin
        rd_word = mem[rd_ch_q][rd_w_q[WA-1:0]];
        for (int b = 0; b < 4; b++) begin
            if ({rd_w_q, 2'(b)} >= (LEN_W+2)'(len_q[rd_ch_q])) rd_word[8*b +: 8] = 8'h00;
        end
    end

    always_ff @(posedge adc_clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (wr_en[c]) begin
                mem[c][cnt_q[c][WA+1:2]][{cnt_q[c][1:0], 3'b000} +: 8] <= grp_res[c][ADC_W-1 -: 8];
            end
        end
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            done_q        <= '0;
            rd_w_q        <= '0;
            rd_ch_q       <= '0;
            left_q        <= '0;
            o_out_data    <= '0;
            o_out_vld     <= 1'b0;
            o_frame_ready <= 1'b0;
            o_frame_size  <= '0;
            o_busy        <= 1'b0;
            o_overrun     <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                ratio_q[c] <= '0;
                len_q[c]   <= '0;
                mode_q[c]  <= '0;
                grp_q[c]   <= '0;
                acc_q[c]   <= '0;
                cnt_q[c]   <= '0;
            end
        end else begin
            o_overrun <= i_sync && (state_q != StIdle);
            case (state_q)
                StIdle: begin
                    if (i_sync) begin
                        for (int c = 0; c < NCH; c++) begin
                            ratio_q[c] <= (i_ratio[c*8 +: 8] == 8'd0) ? 8'd1 : i_ratio[c*8 +: 8];
                            len_q[c]   <= len_clamp[c];
                            mode_q[c]  <= i_mode[c*2 +: 2];
                            grp_q[c]   <= '0;
                            cnt_q[c]   <= '0;
                            done_q[c]  <= (len_clamp[c] == '0);
                        end
                        state_q <= StAcq;
                        o_busy  <= 1'b1;
                    end
                end
                StAcq: begin
                    for (int c = 0; c < NCH; c++) begin
                        if (!done_q[c]) begin
                            if (grp_last[c]) begin
                                grp_q[c]  <= '0;
                                cnt_q[c]  <= cnt_q[c] + LEN_W'(1);
                                done_q[c] <= (cnt_q[c] + LEN_W'(1)) == len_q[c];
                            end else begin
                                grp_q[c] <= grp_q[c] + 8'd1;
                                acc_q[c] <= grp_res[c];
                            end
                        end
                    end
                    if (&done_q) begin
                        o_frame_size <= size_calc;
                        left_q       <= size_calc;
                        rd_ch_q      <= first_ch;
                        rd_w_q       <= '0;
                        if (size_calc == 16'd0) begin
                            state_q <= StIdle;
                            o_busy  <= 1'b0;
                        end else begin
                            state_q       <= StOut;
                            o_frame_ready <= 1'b1;
                        end
                    end
                end
                StOut: begin
                    if ((!o_out_vld || i_out_rdy) && left_q != 16'd0) begin
                        o_out_data <= rd_word;
                        o_out_vld  <= 1'b1;
                        left_q     <= left_q - 16'd1;
                        if (rd_w_q + LEN_W'(1) == nwords[rd_ch_q]) begin
                            rd_w_q  <= '0;
                            rd_ch_q <= next_ch;
                        end else begin
                            rd_w_q <= rd_w_q + LEN_W'(1);
                        end
                    end else if (o_out_vld && i_out_rdy) begin
                        o_out_vld     <= 1'b0;
                        o_out_data    <= '0;
                        o_frame_ready <= 1'b0;
                        o_busy        <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dscope_capture_array.sv
// Directed bench for dscope_capture_array: decimation modes, clamping, packing, stalls,
// overrun handling and mid-readout reset, all against hand-computed words.
module tb_dscope_capture_array;

    localparam int NCH   = 4;
    localparam int ADC_W = 12;
    localparam int DEPTH = 256;
    localparam int LEN_W = 9;

    logic                 adc_clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 i_sync = 1'b0;
    logic [NCH*ADC_W-1:0] i_adc_data = '0;
    logic [NCH*8-1:0]     i_ratio = '0;
    logic [NCH*LEN_W-1:0] i_len = '0;
    logic [NCH*2-1:0]     i_mode = '0;
    logic [31:0]          o_out_data;
    logic                 o_out_vld;
    logic                 i_out_rdy = 1'b0;
    logic                 o_frame_ready;
    logic [15:0]          o_frame_size;
    logic                 o_busy;
    logic                 o_overrun;

    int n_cmp = 0;
    int n_err = 0;
    int scen  = 0;
    logic [31:0] exp_q [$];
    logic [11:0] t29 [8] = '{12'h100, 12'hFF0, 12'h200, 12'h300,
                             12'h050, 12'h060, 12'h070, 12'h010};

    dscope_capture_array #(.NCH(NCH), .ADC_W(ADC_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .adc_clk       (adc_clk),
        .rst_n         (rst_n),
        .i_sync        (i_sync),
        .i_adc_data    (i_adc_data),
        .i_ratio       (i_ratio),
        .i_len         (i_len),
        .i_mode        (i_mode),
        .o_out_data    (o_out_data),
        .o_out_vld     (o_out_vld),
        .i_out_rdy     (i_out_rdy),
        .o_frame_ready (o_frame_ready),
        .o_frame_size  (o_frame_size),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun)
    );

    always #5 adc_clk = ~adc_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge adc_clk);
        @(negedge adc_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [ADC_W-1:0] samp(input int c, input int n);
        case (scen)
            0: return (c == 0) ? 12'((n & 255) << 4) : 12'h000;
            1: return (c == 0) ? t29[n % 8] : 12'h000;
            2: return 12'(((c * 64 + n) & 255) << 4);
            3: return 12'((((n + 37 * c) & 255) << 4) | 15);
            default: return 12'h000;
        endcase
    endfunction

    task automatic start_frame(input logic [31:0] r, input logic [35:0] l, input logic [7:0] m);
        i_ratio = r;
        i_len   = l;
        i_mode  = m;
        i_sync  = 1'b1;
        tick();
        i_sync  = 1'b0;
        // Scramble config after the latch; the frame must not notice.
        i_ratio = $urandom;
        i_len   = 36'({$urandom, $urandom});
        i_mode  = 8'($urandom);
        chk("busy_after_sync", o_busy, 1);
    endtask

    task automatic feed(input int from, input int cnt);
        for (int n = from; n < from + cnt; n++) begin
            for (int c = 0; c < NCH; c++) i_adc_data[c*ADC_W +: ADC_W] = samp(c, n);
            tick();
        end
    endtask

    task automatic collect(input int n, input bit rnd, input bit sync_last, input int stop_after,
                           input logic [15:0] fsize);
        int waitc = 0;
        int lat = 0;
        int got = 0;
        int iters = 0;
        bit stalled = 1'b0;
        logic [31:0] held = '0;
        while (!o_frame_ready && waitc < 400) begin
            tick();
            waitc++;
        end
        chk("frame_ready_seen", o_frame_ready, 1);
        chk("frame_size", o_frame_size, fsize);
        while (!o_out_vld && lat < 5) begin
            tick();
            lat++;
        end
        chk("vld_latency_le3", (lat <= 3), 1);
        while (got < n && iters < 5000) begin
            if (stalled) chk("stall_hold", {o_out_vld, o_out_data}, {1'b1, held});
            i_out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sync_last && got == n - 1 && o_out_vld && i_out_rdy) i_sync = 1'b1;
            if (o_out_vld && i_out_rdy) begin
                chk("word", o_out_data, exp_q.pop_front());
                got++;
                stalled = 1'b0;
            end else if (o_out_vld) begin
                stalled = 1'b1;
                held = o_out_data;
            end
            tick();
            i_sync = 1'b0;
            iters++;
            if (stop_after != 0 && got == stop_after) return;
        end
        i_out_rdy = 1'b0;
        chk("word_count", got, n);
        chk("end_vld", o_out_vld, 0);
        chk("end_frame_ready", o_frame_ready, 0);
        chk("end_busy", o_busy, 0);
        if (sync_last) chk("overrun_on_last", o_overrun, 1);
        if (!rnd) chk("back_to_back_cycles", iters, n);
    endtask

    task automatic ramp8;
        scen = 0;
        start_frame({4{8'd1}}, {9'd0, 9'd0, 9'd0, 9'd8}, 8'h00);
        feed(0, 8);
        exp_q.push_back(32'h03020100);
        exp_q.push_back(32'h07060504);
        collect(2, 1'b0, 1'b0, 0, 16'd2);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_out_data", o_out_data, 0);
        chk("rst_out_vld", o_out_vld, 0);
        chk("rst_frame_ready", o_frame_ready, 0);
        chk("rst_frame_size", o_frame_size, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_overrun", o_overrun, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", o_busy, 0);

        // Ramp on channel 0, other channels empty.
        ramp8();

        // Ratio 4 max, then min, over the same samples.
        scen = 1;
        start_frame({24'd0, 8'd4}, {27'd0, 9'd2}, 8'h01);
        feed(0, 8);
        exp_q.push_back(32'h000007FF);
        collect(1, 1'b0, 1'b0, 0, 16'd1);
        start_frame({24'd0, 8'd4}, {27'd0, 9'd2}, 8'h02);
        feed(0, 8);
        exp_q.push_back(32'h00000110);
        collect(1, 1'b0, 1'b0, 0, 16'd1);

        // len 5 everywhere, mixed ratios/modes, random sink stalls.
        scen = 2;
        start_frame({8'd3, 8'd1, 8'd2, 8'd0}, {4{9'd5}}, 8'h70);
        feed(0, 16);
        exp_q.push_back(32'h03020100); exp_q.push_back(32'h00000004);
        exp_q.push_back(32'h46444240); exp_q.push_back(32'h00000048);
        exp_q.push_back(32'h83828180); exp_q.push_back(32'h00000084);
        exp_q.push_back(32'hCBC8C5C2); exp_q.push_back(32'h000000CE);
        collect(8, 1'b1, 1'b0, 0, 16'd8);

        // Overrun during ACQ and OUT, then i_sync on the final transfer.
        scen = 0;
        start_frame({4{8'd1}}, {9'd0, 9'd0, 9'd0, 9'd8}, 8'h00);
        feed(0, 3);
        i_sync = 1'b1;
        feed(3, 1);
        i_sync = 1'b0;
        chk("overrun_acq", o_overrun, 1);
        feed(4, 1);
        chk("overrun_acq_1cyc", o_overrun, 0);
        feed(5, 3);
        for (int k = 0; k < 20 && !o_frame_ready; k++) tick();
        tick();
        tick();
        i_sync = 1'b1;
        tick();
        i_sync = 1'b0;
        chk("overrun_out", o_overrun, 1);
        chk("stalled_vld", o_out_vld, 1);
        chk("stalled_data", o_out_data, 32'h03020100);
        tick();
        chk("overrun_out_1cyc", o_overrun, 0);
        exp_q.push_back(32'h03020100);
        exp_q.push_back(32'h07060504);
        collect(2, 1'b0, 1'b1, 0, 16'd2);
        tick();
        chk("no_frame_from_last_sync", o_busy, 0);

        // Length 300 clamps to DEPTH on every channel.
        scen = 3;
        start_frame({4{8'd1}}, {4{9'd300}}, 8'h00);
        feed(0, 256);
        for (int c = 0; c < NCH; c++) begin
            for (int w = 0; w < 64; w++) begin
                exp_q.push_back({8'((4*w + 3 + 37*c) & 255), 8'((4*w + 2 + 37*c) & 255),
                                 8'((4*w + 1 + 37*c) & 255), 8'((4*w + 37*c) & 255)});
            end
        end
        collect(256, 1'b0, 1'b0, 0, 16'd256);

        // All lengths zero: straight back to idle, nothing offered.
        start_frame({4{8'd1}}, 36'd0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("zero_len_quiet", {o_out_vld, o_frame_ready, o_busy}, 0);
        end

        // Reset in the middle of readout, 3 of 8 words gone.
        scen = 0;
        start_frame({4{8'd1}}, {9'd0, 9'd0, 9'd0, 9'd32}, 8'h00);
        feed(0, 32);
        for (int w = 0; w < 8; w++) begin
            exp_q.push_back({8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1), 8'(4*w)});
        end
        collect(8, 1'b0, 1'b0, 3, 16'd8);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_data", o_out_data, 0);
        chk("midrst_out_vld", o_out_vld, 0);
        chk("midrst_frame_ready", o_frame_ready, 0);
        chk("midrst_frame_size", o_frame_size, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_overrun", o_overrun, 0);
        tick();
        tick();
        rst_n = 1'b1;
        i_out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_quiet", {o_out_vld, o_frame_ready, o_busy}, 0);
        end
        i_out_rdy = 1'b0;
        exp_q.delete();
        ramp8();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
